axi_lite_router: RTL and testbench
==================================

AXI_LITE_ROUTER -- requirements
Module: axi_lite_router

Interface
REQ-001 Parameter N_SLAVES, default 4: number of downstream AXI-Lite slave ports, range 1..16.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter BASE_ADDR, default {LED, UART, ETH1, ETH2 base addresses}: packed N_SLAVES*ADDR_W array of region bases.
REQ-005 Parameter ADDR_MASK, default 32'hFFFFFF00 per port: packed N_SLAVES*ADDR_W array of region-select masks.
REQ-006 Parameter TIMEOUT, default 255: number of cycles to wait on a downstream slave before aborting with an error.
REQ-007 One clock, reset synchronous active-high.
REQ-008 clk  in  1  system clock; all logic on its rising edge.
REQ-009 rst  in  1  synchronous reset, active-high.
REQ-010 s_awaddr/s_awvalid in ADDR_W/1, s_awready out 1: upstream write address.
REQ-011 s_wdata/s_wlast/s_wvalid in DATA_W/1/1, s_wready out 1: upstream write data.
REQ-012 s_bresp/s_bvalid out 2/1, s_bready in 1: upstream write response.
REQ-013 s_araddr/s_arvalid in ADDR_W/1, s_arready out 1: upstream read address.
REQ-014 s_rdata/s_rresp/s_rlast/s_rvalid out DATA_W/2/1/1, s_rready in 1: upstream read data.
REQ-015 m_awaddr/m_awvalid, m_wdata/m_wlast/m_wvalid, m_bready, m_araddr/m_arvalid, m_rready: outputs packed over N_SLAVES ports; m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rlast, m_rvalid: inputs packed over N_SLAVES ports.

Function
REQ-016 Decode: port i hits when (addr & ADDR_MASK[i]) == BASE_ADDR[i]; on multiple hits, the lowest index wins; with no hit, the transaction is routed to an internal error responder.
REQ-017 The write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR; the read FSM SHALL have states R_IDLE, R_ADDR, R_DATA, R_ERR; the two FSMs run independently and concurrently.
REQ-018 In W_IDLE with s_awvalid=1, the block latches the address and decoded index, then enters W_ADDR next cycle (hit) or W_ERR (miss); s_awready=0 in W_IDLE.
REQ-019 W_ADDR: m_awvalid[sel]=1 and m_awaddr[sel]=addr & ~ADDR_MASK[sel]; s_awready=m_awready[sel]; on that handshake, go to W_DATA.
REQ-020 W_DATA: m_wvalid[sel]/m_wdata/m_wlast follow upstream; s_wready=m_wready[sel]; on the handshake, go to W_RESP.
REQ-021 W_RESP: s_bvalid/s_bresp follow the selected port; m_bready[sel]=s_bready; on the handshake, go to W_IDLE.
REQ-022 Unselected ports SHALL see all valid/ready outputs at 0; the address selection stays frozen from W_IDLE exit until return to W_IDLE, regardless of later changes on s_awaddr.
REQ-023 W_ERR: accept AW and W (ready=1 for one handshake each), then present s_bvalid=1 with s_bresp=2'b11 (DECERR) until s_bready.
REQ-024 Read FSM mirrors the write FSM: R_ADDR forwards AR; R_DATA forwards rdata/rresp/rlast; R_ERR accepts AR, then returns s_rdata=0, s_rresp=2'b11, s_rlast=1.
REQ-025 Timeout counter: cleared on every state entry; increments each cycle in W_ADDR/W_DATA/W_RESP (resp. R_ADDR/R_DATA) without handshake; reaching TIMEOUT drops downstream valids and enters the error state with response 2'b10 (SLVERR) instead of 2'b11.
REQ-026 If AW and AR arrive in the same cycle, both are latched in that cycle; no ordering between read and write is required.
REQ-027 New upstream AW or AR is not accepted until the previous response of the same type completes (one outstanding per direction).

Reset
REQ-028 While rst=1: both FSMs go to IDLE, timeout counters clear, and all ready/valid outputs, s_bresp, s_rresp, s_rdata and all m_* valids are driven 0.
REQ-029 Reset asserted mid-transaction aborts it with no response; the first valid after reset is decoded fresh.

Verification
REQ-030 Write 0xA5 to BASE_ADDR[1]+0x04 -> port 1 sees awaddr=0x04 and wdata=0xA5; other ports stay idle; s_bresp=2'b00.
REQ-031 Read unmapped address 0xDEAD0000 -> s_arready handshake, then s_rvalid=1, s_rresp=2'b11, s_rdata=0; no m_arvalid asserted.
REQ-032 Port 2 holds m_awready=0 -> after 255 cycles, s_bresp=2'b10 and m_awvalid[2] drops.
REQ-033 Simultaneous write to port 0 and read from port 3 -> both complete with correct data and independent timing.
REQ-034 Change s_awaddr while in W_DATA -> routing is unchanged.
REQ-035 Assert rst during W_RESP -> next cycle all outputs are 0; a subsequent write completes normally.

Source files
------------

// File: rtl/axi_lite_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_router: routes one AXI-Lite master to N_SLAVES address regions.  |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module axi_lite_router #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDR =
    {32'h4002_0000, 32'h4001_0000, 32'h4000_1000, 32'h4000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] ADDR_MASK = {N_SLAVES{32'hFFFF_FF00}},
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  // upstream write channels
  input  logic [ADDR_W-1:0]            s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [DATA_W-1:0]            s_wdata,
  input  logic                         s_wlast,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  // upstream read channels
  input  logic [ADDR_W-1:0]            s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rlast,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  // downstream ports, packed by index
  output logic [N_SLAVES*ADDR_W-1:0]   m_awaddr,
  output logic [N_SLAVES-1:0]          m_awvalid,
  input  logic [N_SLAVES-1:0]          m_awready,
  output logic [N_SLAVES*DATA_W-1:0]   m_wdata,
  output logic [N_SLAVES-1:0]          m_wlast,
  output logic [N_SLAVES-1:0]          m_wvalid,
  input  logic [N_SLAVES-1:0]          m_wready,
  input  logic [N_SLAVES*2-1:0]        m_bresp,
  input  logic [N_SLAVES-1:0]          m_bvalid,
  output logic [N_SLAVES-1:0]          m_bready,
  output logic [N_SLAVES*ADDR_W-1:0]   m_araddr,
  output logic [N_SLAVES-1:0]          m_arvalid,
  input  logic [N_SLAVES-1:0]          m_arready,
  input  logic [N_SLAVES*DATA_W-1:0]   m_rdata,
  input  logic [N_SLAVES*2-1:0]        m_rresp,
  input  logic [N_SLAVES-1:0]          m_rlast,
  input  logic [N_SLAVES-1:0]          m_rvalid,
  output logic [N_SLAVES-1:0]          m_rready
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_e;

  // Returns {hit, index}; scanning downward lets the lowest index win.
  function automatic logic [SEL_W:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASK[i*ADDR_W +: ADDR_W]) == BASE_ADDR[i*ADDR_W +: ADDR_W])
        res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- write
  wr_state_e          wr_state_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [SEL_W-1:0]   wr_sel_q;
  logic [CNT_W-1:0]   wr_cnt_q;
  logic               wr_awdone_q;
  logic               wr_wdone_q;
  logic [1:0]         wr_err_q;

  logic [SEL_W:0]     wr_dec;
  logic               wr_tmo;
  logic               wr_aw_hs;
  logic               wr_w_hs;
  logic               wr_b_hs;
  logic [ADDR_W-1:0]  wr_mask;

  assign wr_dec   = decode(s_awaddr);
  assign wr_tmo   = (wr_cnt_q == CNT_LAST);
  assign wr_aw_hs = m_awready[wr_sel_q];
  assign wr_w_hs  = s_wvalid & m_wready[wr_sel_q];
  assign wr_b_hs  = m_bvalid[wr_sel_q] & s_bready;
  assign wr_mask  = ADDR_MASK[wr_sel_q*ADDR_W +: ADDR_W];

  // The done flags tell W_ERR which upstream beats are still owed after a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q  <= W_IDLE;
      wr_addr_q   <= '0;
      wr_sel_q    <= '0;
      wr_cnt_q    <= '0;
      wr_awdone_q <= 1'b0;
      wr_wdone_q  <= 1'b0;
      wr_err_q    <= RESP_DECERR;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          wr_cnt_q <= '0;
          if (s_awvalid) begin
            wr_addr_q   <= s_awaddr;
            wr_sel_q    <= wr_dec[SEL_W-1:0];
            wr_awdone_q <= 1'b0;
            wr_wdone_q  <= 1'b0;
            wr_err_q    <= RESP_DECERR;
            wr_state_q  <= wr_dec[SEL_W] ? W_ADDR : W_ERR;
          end
        end
        W_ADDR: begin
          if (wr_aw_hs) begin
            wr_state_q <= W_DATA;
            wr_cnt_q   <= '0;
          end else if (wr_tmo) begin
            wr_state_q <= W_ERR;
            wr_err_q   <= RESP_SLVERR;
            wr_cnt_q   <= '0;
          end else begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
          end
        end
        W_DATA: begin
          if (wr_w_hs) begin
            wr_state_q <= W_RESP;
            wr_cnt_q   <= '0;
          end else if (wr_tmo) begin
            wr_state_q  <= W_ERR;
            wr_err_q    <= RESP_SLVERR;
            wr_awdone_q <= 1'b1;
            wr_cnt_q    <= '0;
          end else begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
          end
        end
        W_RESP: begin
          if (wr_b_hs) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
          end else if (wr_tmo) begin
            wr_state_q  <= W_ERR;
            wr_err_q    <= RESP_SLVERR;
            wr_awdone_q <= 1'b1;
            wr_wdone_q  <= 1'b1;
            wr_cnt_q    <= '0;
          end else begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
          end
        end
        W_ERR: begin
          wr_cnt_q <= '0;
          if (s_awvalid && !wr_awdone_q) wr_awdone_q <= 1'b1;
          if (s_wvalid && !wr_wdone_q)   wr_wdone_q  <= 1'b1;
          if (wr_awdone_q && wr_wdone_q && s_bready) wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    m_awaddr  = '0;
    m_awvalid = '0;
    m_wdata   = '0;
    m_wlast   = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    if (!rst) begin
      case (wr_state_q)
        W_ADDR: begin
          m_awvalid[wr_sel_q]                   = 1'b1;
          m_awaddr[wr_sel_q*ADDR_W +: ADDR_W]   = wr_addr_q & ~wr_mask;
          s_awready                             = m_awready[wr_sel_q];
        end
        W_DATA: begin
          m_wvalid[wr_sel_q]                    = s_wvalid;
          m_wdata[wr_sel_q*DATA_W +: DATA_W]    = s_wdata;
          m_wlast[wr_sel_q]                     = s_wlast;
          s_wready                              = m_wready[wr_sel_q];
        end
        W_RESP: begin
          s_bvalid           = m_bvalid[wr_sel_q];
          s_bresp            = m_bresp[wr_sel_q*2 +: 2];
          m_bready[wr_sel_q] = s_bready;
        end
        W_ERR: begin
          s_awready = !wr_awdone_q;
          s_wready  = !wr_wdone_q;
          s_bvalid  = wr_awdone_q & wr_wdone_q;
          s_bresp   = (wr_awdone_q & wr_wdone_q) ? wr_err_q : 2'b00;
        end
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------------------- read
  rd_state_e          rd_state_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [SEL_W-1:0]   rd_sel_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic               rd_ardone_q;
  logic [1:0]         rd_err_q;

  logic [SEL_W:0]     rd_dec;
  logic               rd_tmo;
  logic               rd_ar_hs;
  logic               rd_r_hs;
  logic [ADDR_W-1:0]  rd_mask;

  assign rd_dec   = decode(s_araddr);
  assign rd_tmo   = (rd_cnt_q == CNT_LAST);
  assign rd_ar_hs = m_arready[rd_sel_q];
  assign rd_r_hs  = m_rvalid[rd_sel_q] & s_rready;
  assign rd_mask  = ADDR_MASK[rd_sel_q*ADDR_W +: ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q  <= R_IDLE;
      rd_addr_q   <= '0;
      rd_sel_q    <= '0;
      rd_cnt_q    <= '0;
      rd_ardone_q <= 1'b0;
      rd_err_q    <= RESP_DECERR;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          rd_cnt_q <= '0;
          if (s_arvalid) begin
            rd_addr_q   <= s_araddr;
            rd_sel_q    <= rd_dec[SEL_W-1:0];
            rd_ardone_q <= 1'b0;
            rd_err_q    <= RESP_DECERR;
            rd_state_q  <= rd_dec[SEL_W] ? R_ADDR : R_ERR;
          end
        end
        R_ADDR: begin
          if (rd_ar_hs) begin
            rd_state_q <= R_DATA;
            rd_cnt_q   <= '0;
          end else if (rd_tmo) begin
            rd_state_q <= R_ERR;
            rd_err_q   <= RESP_SLVERR;
            rd_cnt_q   <= '0;
          end else begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          end
        end
        R_DATA: begin
          if (rd_r_hs) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
          end else if (rd_tmo) begin
            rd_state_q  <= R_ERR;
            rd_err_q    <= RESP_SLVERR;
            rd_ardone_q <= 1'b1;
            rd_cnt_q    <= '0;
          end else begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          end
        end
        R_ERR: begin
          rd_cnt_q <= '0;
          if (s_arvalid && !rd_ardone_q) rd_ardone_q <= 1'b1;
          if (rd_ardone_q && s_rready)   rd_state_q  <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    s_rlast   = 1'b0;
    m_araddr  = '0;
    m_arvalid = '0;
    m_rready  = '0;
    if (!rst) begin
      case (rd_state_q)
        R_ADDR: begin
          m_arvalid[rd_sel_q]                 = 1'b1;
          m_araddr[rd_sel_q*ADDR_W +: ADDR_W] = rd_addr_q & ~rd_mask;
          s_arready                           = m_arready[rd_sel_q];
        end
        R_DATA: begin
          s_rvalid           = m_rvalid[rd_sel_q];
          s_rdata            = m_rdata[rd_sel_q*DATA_W +: DATA_W];
          s_rresp            = m_rresp[rd_sel_q*2 +: 2];
          s_rlast            = m_rlast[rd_sel_q];
          m_rready[rd_sel_q] = s_rready;
        end
        R_ERR: begin
          s_arready = !rd_ardone_q;
          s_rvalid  = rd_ardone_q;
          s_rresp   = rd_ardone_q ? rd_err_q : 2'b00;
          s_rlast   = rd_ardone_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_lite_router: directed self-checking bench for axi_lite_router.     |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_axi_lite_router;

  logic clk = 1'b0;
  logic rst;
  logic [31:0]  s_awaddr, s_wdata, s_araddr, s_rdata;
  logic         s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [1:0]   s_bresp, s_rresp;
  logic         s_bvalid, s_bready, s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [127:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]   m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [3:0]   m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [7:0]   m_bresp, m_rresp;
  logic [24:0]  all_vr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign all_vr = {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                   m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};

  axi_lite_router dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wlast = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0;
    m_awready = '0; m_wready = '0; m_bresp = '0; m_bvalid = '0;
    m_arready = '0; m_rdata = '0; m_rresp = '0; m_rlast = '0; m_rvalid = '0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) tick;
    s_awaddr = 32'h4000_0000; s_awvalid = 1; s_araddr = 32'h4000_0000; s_arvalid = 1;
    m_awready = 4'hF; m_arready = 4'hF;
    tick;
    n_cmp++; if (all_vr !== 25'd0) begin n_err++; $display("FAIL rst_hold_vr: got %h exp 0", all_vr); end
    n_cmp++; if ({s_bresp, s_rresp, s_rdata} !== 36'd0) begin n_err++; $display("FAIL rst_hold_resp: got %h exp 0", {s_bresp, s_rresp, s_rdata}); end
    clear_inputs();
    rst = 0;
    tick;
    n_cmp++; if (all_vr !== 25'd0) begin n_err++; $display("FAIL post_rst_vr: got %h exp 0", all_vr); end
  endtask

  task automatic test_write_hit;
    s_awaddr = 32'h4000_1004; s_awvalid = 1; s_wdata = 32'hA5; s_wlast = 1; s_wvalid = 1; s_bready = 1;
    #1;
    n_cmp++; if (s_awready !== 1'b0) begin n_err++; $display("FAIL wh_idle_awready: got %b exp 0", s_awready); end
    tick;
    n_cmp++; if (m_awvalid !== 4'b0010) begin n_err++; $display("FAIL wh_awvalid: got %b exp 0010", m_awvalid); end
    n_cmp++; if (m_awaddr !== 128'h0000_0000_0000_0000_0000_0004_0000_0000) begin n_err++; $display("FAIL wh_awaddr: got %h", m_awaddr); end
    m_awready = 4'b0010; #1;
    n_cmp++; if (s_awready !== 1'b1) begin n_err++; $display("FAIL wh_awready: got %b exp 1", s_awready); end
    tick;
    s_awvalid = 0; m_awready = 0; #1;
    n_cmp++; if ({m_awvalid, m_wvalid, m_wlast} !== 12'b0000_0010_0010) begin n_err++; $display("FAIL wh_wvalid: got %b exp 000000100010", {m_awvalid, m_wvalid, m_wlast}); end
    n_cmp++; if (m_wdata !== 128'h0000_0000_0000_0000_0000_00A5_0000_0000) begin n_err++; $display("FAIL wh_wdata: got %h", m_wdata); end
    m_wready = 4'b0010; #1;
    n_cmp++; if (s_wready !== 1'b1) begin n_err++; $display("FAIL wh_wready: got %b exp 1", s_wready); end
    tick;
    s_wvalid = 0; m_wready = 0; #1;
    n_cmp++; if ({s_bvalid, m_bready} !== 5'b0_0010) begin n_err++; $display("FAIL wh_bwait: got %b exp 00010", {s_bvalid, m_bready}); end
    m_bvalid = 4'b0010; #1;
    n_cmp++; if ({s_bvalid, s_bresp} !== 3'b100) begin n_err++; $display("FAIL wh_bresp: got %b exp 100", {s_bvalid, s_bresp}); end
    tick;
    clear_inputs(); #1;
    n_cmp++; if (all_vr !== 25'd0) begin n_err++; $display("FAIL wh_done: got %h exp 0", all_vr); end
  endtask

  task automatic test_read_unmapped;
    s_araddr = 32'hDEAD_0000; s_arvalid = 1; #1;
    n_cmp++; if (s_arready !== 1'b0) begin n_err++; $display("FAIL ru_idle_arready: got %b exp 0", s_arready); end
    tick;
    n_cmp++; if ({s_arready, s_rvalid, m_arvalid} !== 6'b10_0000) begin n_err++; $display("FAIL ru_accept: got %b exp 100000", {s_arready, s_rvalid, m_arvalid}); end
    tick;
    s_arvalid = 0; #1;
    n_cmp++; if ({s_rvalid, s_rresp, s_rlast, s_arready, m_arvalid} !== 9'b1_11_1_0_0000) begin n_err++; $display("FAIL ru_resp: got %b exp 111100000", {s_rvalid, s_rresp, s_rlast, s_arready, m_arvalid}); end
    n_cmp++; if (s_rdata !== 32'd0) begin n_err++; $display("FAIL ru_rdata: got %h exp 0", s_rdata); end
    s_rready = 1;
    tick;
    s_rready = 0; #1;
    n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL ru_done: got %b exp 0", s_rvalid); end
  endtask

  task automatic test_write_unmapped;
    s_awaddr = 32'h0000_0010; s_awvalid = 1; s_wdata = 32'h77; s_wvalid = 1;
    tick;
    n_cmp++; if ({s_awready, s_wready, s_bvalid, m_awvalid} !== 7'b110_0000) begin n_err++; $display("FAIL wu_accept: got %b exp 1100000", {s_awready, s_wready, s_bvalid, m_awvalid}); end
    tick;
    s_awvalid = 0; s_wvalid = 0; #1;
    n_cmp++; if ({s_bvalid, s_bresp, m_awvalid, m_wvalid} !== 11'b1_11_0000_0000) begin n_err++; $display("FAIL wu_resp: got %b exp 11100000000", {s_bvalid, s_bresp, m_awvalid, m_wvalid}); end
    s_bready = 1;
    tick;
    s_bready = 0; #1;
    n_cmp++; if (s_bvalid !== 1'b0) begin n_err++; $display("FAIL wu_done: got %b exp 0", s_bvalid); end
  endtask

  task automatic test_timeout;
    int n;
    s_awaddr = 32'h4001_0000; s_awvalid = 1; s_wdata = 32'h99; s_wvalid = 1;
    tick;
    n = 0;
    while (m_awvalid[2] === 1'b1 && n < 300) begin
      n++;
      tick;
    end
    n_cmp++; if (n !== 255) begin n_err++; $display("FAIL to_cycles: got %0d exp 255", n); end
    n_cmp++; if ({m_awvalid, s_awready, s_wready, s_bvalid} !== 7'b0000_110) begin n_err++; $display("FAIL to_err_entry: got %b exp 0000110", {m_awvalid, s_awready, s_wready, s_bvalid}); end
    tick;
    s_awvalid = 0; s_wvalid = 0; #1;
    n_cmp++; if ({s_bvalid, s_bresp} !== 3'b110) begin n_err++; $display("FAIL to_slverr: got %b exp 110", {s_bvalid, s_bresp}); end
    s_bready = 1;
    tick;
    s_bready = 0; #1;
    n_cmp++; if (all_vr !== 25'd0) begin n_err++; $display("FAIL to_done: got %h exp 0", all_vr); end
  endtask

  task automatic test_concurrent;
    s_awaddr = 32'h4000_0010; s_awvalid = 1; s_wdata = 32'h1234_5678; s_wvalid = 1;
    s_araddr = 32'h4002_0020; s_arvalid = 1;
    m_awready = 4'b0001; m_arready = 4'b1000;
    tick;
    n_cmp++; if ({m_awvalid, m_arvalid, s_awready, s_arready} !== 10'b0001_1000_11) begin n_err++; $display("FAIL cc_addr_vr: got %b exp 0001100011", {m_awvalid, m_arvalid, s_awready, s_arready}); end
    n_cmp++; if ({m_araddr[127:96], m_awaddr[31:0]} !== {32'h20, 32'h10}) begin n_err++; $display("FAIL cc_addrs: got %h exp 0000002000000010", {m_araddr[127:96], m_awaddr[31:0]}); end
    tick;
    s_awvalid = 0; s_arvalid = 0; m_awready = 0; m_arready = 0;
    m_rvalid = 4'b1000; m_rdata[127:96] = 32'hCAFE_F00D; m_rlast = 4'b1000; s_rready = 1; #1;
    n_cmp++; if ({m_wvalid, m_wdata[31:0]} !== {4'b0001, 32'h1234_5678}) begin n_err++; $display("FAIL cc_wdata: got %h", {m_wvalid, m_wdata[31:0]}); end
    n_cmp++; if ({s_rvalid, s_rlast, s_rresp, m_rready, s_rdata} !== {1'b1, 1'b1, 2'b00, 4'b1000, 32'hCAFE_F00D}) begin n_err++; $display("FAIL cc_rdata: got %h", {s_rvalid, s_rlast, s_rresp, m_rready, s_rdata}); end
    tick;
    m_rvalid = 0; s_rready = 0; #1;
    n_cmp++; if ({s_rvalid, m_wvalid} !== 5'b0_0001) begin n_err++; $display("FAIL cc_wr_pending: got %b exp 00001", {s_rvalid, m_wvalid}); end
    m_wready = 4'b0001;
    tick;
    s_wvalid = 0; m_wready = 0; m_bvalid = 4'b0001; s_bready = 1; #1;
    n_cmp++; if ({s_bvalid, s_bresp} !== 3'b100) begin n_err++; $display("FAIL cc_bresp: got %b exp 100", {s_bvalid, s_bresp}); end
    tick;
    clear_inputs(); #1;
    n_cmp++; if (all_vr !== 25'd0) begin n_err++; $display("FAIL cc_done: got %h exp 0", all_vr); end
  endtask

  task automatic test_addr_change;
    s_awaddr = 32'h4000_1008; s_awvalid = 1; m_awready = 4'b0010;
    tick;
    tick;
    s_awvalid = 0; m_awready = 0; s_awaddr = 32'h4002_0000;
    s_wdata = 32'h0BAD_BEEF; s_wvalid = 1; #1;
    n_cmp++; if ({m_awvalid, m_wvalid} !== 8'b0000_0010) begin n_err++; $display("FAIL ac_wroute: got %b exp 00000010", {m_awvalid, m_wvalid}); end
    m_wready = 4'b0010;
    tick;
    s_wvalid = 0; m_wready = 0; s_bready = 1;
    m_bvalid = 4'b1010; m_bresp = 8'b10_00_01_00; #1;
    n_cmp++; if ({s_bvalid, s_bresp, m_bready} !== 7'b1_01_0010) begin n_err++; $display("FAIL ac_broute: got %b exp 1010010", {s_bvalid, s_bresp, m_bready}); end
    tick;
    clear_inputs(); #1;
    n_cmp++; if (all_vr !== 25'd0) begin n_err++; $display("FAIL ac_done: got %h exp 0", all_vr); end
  endtask

  task automatic test_reset_mid;
    s_awaddr = 32'h4000_0000; s_awvalid = 1; s_wdata = 32'h11; s_wvalid = 1;
    m_awready = 4'b0001; m_wready = 4'b0001;
    tick;
    tick;
    s_awvalid = 0;
    tick;
    s_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 4'b0001; m_bresp = 8'b0000_0001; #1;
    n_cmp++; if ({s_bvalid, s_bresp} !== 3'b101) begin n_err++; $display("FAIL rm_in_resp: got %b exp 101", {s_bvalid, s_bresp}); end
    rst = 1; #1;
    n_cmp++; if ({all_vr, s_bresp} !== 27'd0) begin n_err++; $display("FAIL rm_rst_outs: got %h exp 0", {all_vr, s_bresp}); end
    tick;
    rst = 0; #1;
    n_cmp++; if ({all_vr, s_bresp} !== 27'd0) begin n_err++; $display("FAIL rm_after_rst: got %h exp 0", {all_vr, s_bresp}); end
    clear_inputs();
    s_awaddr = 32'h4001_0044; s_awvalid = 1; s_wdata = 32'h55; s_wvalid = 1; s_bready = 1;
    m_awready = 4'b0100; m_wready = 4'b0100;
    tick;
    n_cmp++; if ({m_awvalid, m_awaddr[95:64]} !== {4'b0100, 32'h44}) begin n_err++; $display("FAIL rm_new_aw: got %h", {m_awvalid, m_awaddr[95:64]}); end
    tick;
    s_awvalid = 0; #1;
    n_cmp++; if ({m_wvalid, m_wdata[95:64]} !== {4'b0100, 32'h55}) begin n_err++; $display("FAIL rm_new_w: got %h", {m_wvalid, m_wdata[95:64]}); end
    tick;
    s_wvalid = 0; m_bvalid = 4'b0100; #1;
    n_cmp++; if ({s_bvalid, s_bresp} !== 3'b100) begin n_err++; $display("FAIL rm_new_b: got %b exp 100", {s_bvalid, s_bresp}); end
    tick;
    clear_inputs(); #1;
    n_cmp++; if (all_vr !== 25'd0) begin n_err++; $display("FAIL rm_done: got %h exp 0", all_vr); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_write_hit();
    test_read_unmapped();
    test_write_unmapped();
    test_timeout();
    test_concurrent();
    test_addr_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
